// File: rtl/cnn_layer_sequencer_pkg.sv
// cnn_pkg: shared FSM state type, stage indices and default stage count for the CNN frame sequencer
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, ERROR} seq_state_t;
  localparam int STG_CONV1 = 0;
  localparam int STG_RELU = 1;
  localparam int STG_POOL = 2;
  localparam int STG_DENSE = 3;
  localparam int DEFAULT_NUM_STAGES = 4;
endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: frame request, engine handshake and status signals of the layer sequencer
interface cnn_layer_sequencer_if #(
  parameter int NUM_STAGES = cnn_pkg::DEFAULT_NUM_STAGES
);
  localparam int STG_W = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  logic frame_start;
  logic abort;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_start;
  logic [STG_W-1:0] cur_stage;
  logic busy;
  logic frame_done;
  logic start_dropped;
  logic error;
  logic [STG_W-1:0] err_stage;
  modport master (
    output frame_start, abort, stage_done,
    input stage_start, cur_stage, busy, frame_done, start_dropped, error, err_stage
  );
  modport slave (
    input frame_start, abort, stage_done,
    output stage_start, cur_stage, busy, frame_done, start_dropped, error, err_stage
  );
endinterface

// File: rtl/cnn_layer_sequencer_watchdog.sv
// seq_watchdog: counts waiting cycles of one stage and flags expiry as the count reaches TIMEOUT_CYCLES-1
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  // expiry fires on the cycle whose increment would reach TIMEOUT_CYCLES-1
  assign expired = enable && cnt == W'(TIMEOUT_CYCLES - 2);
  // cycle counter, restarted at every stage launch
  always_ff @(posedge clk)
    if (!reset || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs each layer engine once per frame in index order; SEQ_WATCHDOG_EN adds a per-stage hang watchdog
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int STG_W = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1
) (
  input logic clk,
  input logic reset,
  cnn_layer_sequencer_if.slave bus
);
  localparam logic [STG_W-1:0] LAST = STG_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);
  seq_state_t state;
  logic done;
  logic expired;
  assign done = bus.stage_done[bus.cur_stage];
`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(state == LAUNCH),
    .enable(state == WAIT && !done),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  // frame FSM with all outputs registered; abort outranks every other event outside IDLE
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      bus.cur_stage <= '0;
      bus.stage_start <= '0;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.start_dropped <= 1'b0;
      bus.error <= 1'b0;
      bus.err_stage <= '0;
    end else begin
      bus.stage_start <= '0;
      bus.frame_done <= 1'b0;
      bus.start_dropped <= bus.frame_start && state != IDLE;
      if (bus.abort && state != IDLE) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.error <= 1'b0;
        bus.err_stage <= '0;
      end else
        case (state)
          IDLE:
            if (bus.frame_start && !bus.abort) begin
              state <= LAUNCH;
              bus.cur_stage <= '0;
              bus.busy <= 1'b1;
              bus.stage_start <= ONE;
            end
          LAUNCH: state <= WAIT;
          WAIT:
            if (done && bus.cur_stage == LAST) begin
              state <= DONE;
              bus.frame_done <= 1'b1;
            end else if (done) begin
              state <= LAUNCH;
              bus.cur_stage <= bus.cur_stage + 1'b1;
              bus.stage_start <= ONE << (bus.cur_stage + 1'b1);
            end else if (expired) begin
              state <= ERROR;
              bus.error <= 1'b1;
              bus.err_stage <= bus.cur_stage;
              bus.busy <= 1'b0;
            end
          DONE: begin
            state <= IDLE;
            bus.busy <= 1'b0;
          end
          default: state <= state;
        endcase
    end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed frames against stub engines answering 5 cycles after each start
module tb_cnn_layer_sequencer;
  localparam int NS = 3;
  localparam int TO = 16;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int rel = 0;
  int cnt [NS];
  logic [NS-1:0] hang = '0;
  int fd_n;
  int ss_n;
  cnn_layer_sequencer_if #(.NUM_STAGES(NS)) bus ();
  cnn_layer_sequencer #(.NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, rel, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    rel++;
    bus.frame_start = 1'b0;
    bus.abort = 1'b0;
    bus.stage_done = '0;
    for (int i = 0; i < NS; i++)
      if (bus.stage_start[i]) cnt[i] = 5;
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0 && !hang[i]) bus.stage_done[i] = 1'b1;
      end
  endtask
  initial begin
    bus.frame_start = 1'b0;
    bus.abort = 1'b0;
    bus.stage_done = '0;
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    repeat (2) cyc();
    check("rst_stage_start", bus.stage_start, 0);
    check("rst_cur_stage", bus.cur_stage, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_start_dropped", bus.start_dropped, 0);
    check("rst_error", bus.error, 0);
    check("rst_err_stage", bus.err_stage, 0);
    reset = 1'b1;
    cyc();
    for (int t = 0; t < 4; t++) begin
      fd_n = 0;
      ss_n = 0;
      rel = 0;
      bus.frame_start = 1'b1;
      repeat (21) begin
        cyc();
        if (t == 1 && rel == 1) bus.stage_done[0] = 1'b1;
        if (t == 1 && rel == 3) bus.stage_done[2] = 1'b1;
        if (t == 2 && rel == 4) bus.frame_start = 1'b1;
        if (t == 3 && rel == 19) bus.frame_start = 1'b1;
        fd_n += int'(bus.frame_done);
        ss_n += $countones(bus.stage_start);
        check("stage_start", bus.stage_start, rel == 1 ? 1 : rel == 7 ? 2 : rel == 13 ? 4 : 0);
        check("busy", bus.busy, rel >= 1 && rel <= 19);
        check("frame_done", bus.frame_done, rel == 19);
        check("start_dropped", bus.start_dropped, (t == 2 && rel == 5) || (t == 3 && rel == 20));
      end
      check("frame_done_count", fd_n, 1);
      check("stage_start_count", ss_n, 3);
      check("cur_stage_hold", bus.cur_stage, 2);
    end
    rel = 0;
    bus.frame_start = 1'b1;
    repeat (32) begin
      cyc();
      if (rel == 8) bus.abort = 1'b1;
      if (rel == 12) bus.frame_start = 1'b1;
      check("abort_busy", bus.busy, (rel >= 1 && rel <= 8) || (rel >= 13 && rel <= 31));
      check("abort_frame_done", bus.frame_done, rel == 31);
      if (rel == 9) check("abort_cur_stage", bus.cur_stage, 1);
      if (rel == 13) check("restart_stage_start", bus.stage_start, 1);
    end
    rel = 0;
    hang = 3'b010;
    bus.frame_start = 1'b1;
    repeat (28) begin
      cyc();
      if (rel == 24) bus.frame_start = 1'b1;
      if (rel == 26) bus.abort = 1'b1;
      if (rel == 22) begin
        check("wd_busy_before", bus.busy, 1);
        check("wd_error_before", bus.error, 0);
      end
      if (rel == 23) begin
        check("wd_busy", bus.busy, !WD);
        check("wd_error", bus.error, WD);
        check("wd_err_stage", bus.err_stage, WD ? 1 : 0);
      end
      if (rel == 25) begin
        check("wd_start_dropped", bus.start_dropped, 1);
        check("wd_error_held", bus.error, WD);
      end
      if (rel == 27) begin
        check("wd_abort_busy", bus.busy, 0);
        check("wd_abort_error", bus.error, 0);
        check("wd_abort_err_stage", bus.err_stage, 0);
      end
    end
    hang = '0;
    rel = 0;
    bus.frame_start = 1'b1;
    repeat (38) begin
      cyc();
      reset = !(rel == 15);
      if (rel == 17) bus.frame_start = 1'b1;
      if (rel == 13) check("mid_stage_start", bus.stage_start, 4);
      if (rel == 16) begin
        check("mrst_stage_start", bus.stage_start, 0);
        check("mrst_cur_stage", bus.cur_stage, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_frame_done", bus.frame_done, 0);
        check("mrst_error", bus.error, 0);
      end
      if (rel <= 16) check("mrst_no_frame_done", bus.frame_done, 0);
      if (rel >= 17) begin
        check("post_busy", bus.busy, rel >= 18 && rel <= 36);
        check("post_frame_done", bus.frame_done, rel == 36);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Top-level frame controller for the CNN inference path.
- Launches each layer engine in a fixed order (conv2d → relu → maxpool → dense, …) using the engines' one-cycle start/done handshakes.
- Reports frame completion, drops overlapping frame requests, and supports abort.
- A compile-time watchdog flags a hung layer.

Parameters:
- NUM_STAGES, 4: number of sequenced layer engines; stage 0 runs first.
- TIMEOUT_CYCLES, 1048576: per-stage watchdog limit in cycles; must be ≥ 2.
- STG_W, $clog2(NUM_STAGES) (min 1): stage index width; derived, not user-set.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- frame_start  in  1  one-cycle request to run all stages once
- abort  in  1  cancel the current frame
- stage_done  in  NUM_STAGES  per-engine done pulses
- stage_start  out  NUM_STAGES  one-hot start pulse to engines
- cur_stage  out  STG_W  index of the active or last-launched stage
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the last stage completes
- start_dropped  out  1  one-cycle pulse when frame_start is ignored
- error  out  1  sticky watchdog error (SEQ_WATCHDOG_EN only; otherwise tied 0)
- err_stage  out  STG_W  stage that timed out (valid while error=1)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all outputs 0; cur_stage 0; watchdog counter 0. Reset mid-frame abandons the frame with no frame_done. Engines are not reset by this block.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT, DONE, ERROR.
- IDLE: frame_start=1 at edge t → LAUNCH at t+1, cur_stage=0, busy=1 from t+1.
- LAUNCH (exactly 1 cycle):
  - stage_start[cur_stage]=1, all other bits 0.
  - Next state WAIT; watchdog counter cleared.
  - stage_done is ignored in this cycle.
- WAIT:
  - Only stage_done[cur_stage] is sampled; other bits are ignored.
  - If done is sampled at edge d and cur_stage<NUM_STAGES-1: cur_stage+1 and LAUNCH at d+1, so the next start is visible one cycle after done.
  - If cur_stage==NUM_STAGES-1: DONE at d+1.
- DONE (1 cycle): frame_done=1, busy=1; next state IDLE, busy=0. cur_stage keeps the last index until the next frame.
- Latency, frame_start to frame_done: 1 + Σ(stage_i cycles + 1), where stage_i = cycles from start pulse to done pulse.
- frame_start while not IDLE: ignored and start_dropped=1 next cycle. A request is not queued.
- frame_start coinciding with the DONE cycle: also dropped.
- abort=1 in LAUNCH/WAIT/DONE:
  - Next state IDLE, busy=0, no frame_done.
  - A stage_start pulse already issued is not retracted.
- abort=1 in ERROR: clears error and err_stage, next state IDLE.
- abort has priority over frame_start in the same cycle.
- abort in IDLE: no effect.
- Simultaneous stage_done and watchdog expiry in WAIT: done wins.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined:
  - In WAIT, a counter increments every cycle without done.
  - When it reaches TIMEOUT_CYCLES-1 with no done: ERROR next cycle, error=1, err_stage=cur_stage, busy=0.
  - ERROR ignores frame_start (start_dropped pulses) and all stage_done.
  - Exit is only by abort or reset.
- Undefined: no counter logic, ERROR is unreachable, error and err_stage are constant 0, and WAIT waits indefinitely.

Decomposition:
- Package cnn_pkg holds:
  - seq_state_t enum {IDLE, LAUNCH, WAIT, DONE, ERROR};
  - stage index constants STG_CONV1=0, STG_RELU=1, STG_POOL=2, STG_DENSE=3;
  - default NUM_STAGES.
- One sub-module, seq_watchdog (clear, enable, expired; parameter TIMEOUT_CYCLES), instantiated only under SEQ_WATCHDOG_EN.

Test Plan (NUM_STAGES=3, TIMEOUT_CYCLES=16, watchdog enabled unless noted):
- Normal frame: frame_start at cycle 0; each stub engine returns done 5 cycles after its start → stage_start = 001@1, 010@7, 100@13; frame_done@19; busy high cycles 1–19.
- Overlap: second frame_start at cycle 4 of a frame → start_dropped@5; exactly one frame_done; stage_start count 3.
- Wrong/early done: stage_done[2] pulsed during stage 0 WAIT, and stage_done[0] during its LAUNCH cycle → both ignored; sequence timing unchanged from the normal case.
- Abort: abort at cycle 8 (stage 1 WAIT) → busy=0@9, no frame_done, cur_stage=1; a new frame_start@12 restarts at stage 0 (stage_start=001@13).
- Watchdog: stage 1 never returns done → error=1, err_stage=1, busy=0 sixteen cycles after its start; frame_start then gives start_dropped; abort clears error. Without SEQ_WATCHDOG_EN, the same stimulus keeps busy=1 indefinitely and error stays 0.
- Reset mid-frame: reset=0 for one cycle during stage 2 → all outputs 0 on the next cycle; a following frame completes normally.
